// File: rtl/rgb_de_receiver.sv
// DE-only RGB565 receiver: frame/line recovery, pixel coordinates, resolution lock (RGB_RX_ID_CHECK_EN adds panel-ID check).
// Latency: 2 lcd_clk cycles from in_de/in_rgb to pix_*; frame_end VBLANK_MIN+2 cycles after the last DE-high sample.
// Backpressure: none, the pixel stream cannot be stalled.
module rgb_de_receiver #(
  parameter int VBLANK_MIN = 2048,
  parameter int GAP_W      = 12
) (
  input  logic        lcd_clk,
  input  logic        sys_rst,
  input  logic [15:0] lcd_id,
  input  logic        in_de,
  input  logic [15:0] in_rgb,
  output logic        pix_valid,
  output logic [15:0] pix_data,
  output logic [10:0] pix_xpos,
  output logic [10:0] pix_ypos,
  output logic        frame_start,
  output logic        line_end,
  output logic        frame_end,
  output logic [10:0] meas_h_disp,
  output logic [10:0] meas_v_disp,
  output logic        locked,
  output logic        err_pulse,
  output logic [7:0]  err_cnt
);

  typedef enum logic [1:0] {SEARCH, ACQUIRE, LOCKED} state_t;

  localparam logic [GAP_W-1:0] GAP_MAX  = GAP_W'(VBLANK_MIN);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(VBLANK_MIN - 1);
  localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1);
  localparam logic [10:0]      XY_MAX   = 11'd2047;

  state_t           state;
  logic [GAP_W-1:0] gap_cnt;
  logic             de1, de2, sof1, hit1, hit2;
  logic [15:0]      rgb1;
  logic [10:0]      x_cnt, y_cnt, x_nxt, y_nxt, line_len;
  logic [10:0]      width_st, line_cnt;
  logic             line_seen, frame_bad;
  logic             blank_hit, active, run_start, last_beat, id_ok, good;

  // A DE rise on the edge that would complete the run does not count as a blank.
  assign blank_hit = !in_de && (gap_cnt == GAP_LAST);
  assign active    = (state != SEARCH);
  assign run_start = de1 && !de2;
  assign last_beat = active && de1 && !in_de;
  assign line_len  = x_nxt + 11'd1;

  always_comb begin
    x_nxt = x_cnt;
    y_nxt = y_cnt;
    if (run_start) begin
      x_nxt = 11'd0;
      y_nxt = sof1 ? 11'd0 : ((y_cnt == XY_MAX) ? y_cnt : y_cnt + 11'd1);
    end else if (de1 && (x_cnt != XY_MAX)) begin
      x_nxt = x_cnt + 11'd1;
    end
  end

`ifdef RGB_RX_ID_CHECK_EN
  logic [10:0] exp_h, exp_v;
  always_comb begin
    exp_h = 11'd480;
    exp_v = 11'd272;
    case (lcd_id)
      16'h7084, 16'h4384: begin exp_h = 11'd800;  exp_v = 11'd480; end
      16'h7016:           begin exp_h = 11'd1024; exp_v = 11'd600; end
      16'h1018:           begin exp_h = 11'd1280; exp_v = 11'd800; end
      default:            ;
    endcase
  end
  assign id_ok = (width_st == exp_h) && (line_cnt == exp_v);
`else
  logic unused_lcd_id;
  assign unused_lcd_id = ^lcd_id;
  assign id_ok         = 1'b1;
`endif

  assign good = !frame_bad && id_ok &&
                ((state == ACQUIRE) || ((width_st == meas_h_disp) && (line_cnt == meas_v_disp)));

  // Stage 1: input capture and DE-low run tracking.
  always_ff @(posedge lcd_clk) begin
    if (sys_rst) begin
      gap_cnt <= '0;
      de1     <= 1'b0;
      rgb1    <= 16'd0;
      sof1    <= 1'b0;
      hit1    <= 1'b0;
      hit2    <= 1'b0;
    end else begin
      de1  <= in_de;
      rgb1 <= in_rgb;
      sof1 <= in_de && (gap_cnt == GAP_MAX);
      hit1 <= blank_hit;
      hit2 <= hit1;
      if (in_de)
        gap_cnt <= '0;
      else if (gap_cnt != GAP_MAX)
        gap_cnt <= gap_cnt + GAP_ONE;
    end
  end

  // Stage 2: coordinates, strobes, measurement and lock state.
  always_ff @(posedge lcd_clk) begin
    if (sys_rst) begin
      state       <= SEARCH;
      de2         <= 1'b0;
      x_cnt       <= 11'd0;
      y_cnt       <= 11'd0;
      width_st    <= 11'd0;
      line_cnt    <= 11'd0;
      line_seen   <= 1'b0;
      frame_bad   <= 1'b0;
      pix_valid   <= 1'b0;
      pix_data    <= 16'd0;
      pix_xpos    <= 11'd0;
      pix_ypos    <= 11'd0;
      frame_start <= 1'b0;
      line_end    <= 1'b0;
      frame_end   <= 1'b0;
      meas_h_disp <= 11'd0;
      meas_v_disp <= 11'd0;
      locked      <= 1'b0;
      err_pulse   <= 1'b0;
      err_cnt     <= 8'd0;
    end else begin
      de2         <= de1;
      x_cnt       <= x_nxt;
      y_cnt       <= y_nxt;
      frame_end   <= 1'b0;
      err_pulse   <= 1'b0;
      pix_valid   <= active && de1;
      pix_data    <= (active && de1) ? rgb1  : 16'd0;
      pix_xpos    <= (active && de1) ? x_nxt : 11'd0;
      pix_ypos    <= (active && de1) ? y_nxt : 11'd0;
      frame_start <= active && run_start && sof1;
      line_end    <= last_beat;

      if (active && de1 && (x_nxt == XY_MAX))
        frame_bad <= 1'b1;

      if (last_beat) begin
        line_seen <= 1'b1;
        line_cnt  <= (y_nxt == XY_MAX) ? XY_MAX : y_nxt + 11'd1;
        if (y_nxt == 11'd0)
          width_st <= line_len;
        else if (line_len != width_st)
          frame_bad <= 1'b1;
      end

      if (hit2) begin
        if (state == SEARCH) begin
          state     <= ACQUIRE;
          line_seen <= 1'b0;
          frame_bad <= 1'b0;
        end else if (line_seen) begin
          frame_end   <= 1'b1;
          meas_h_disp <= width_st;
          meas_v_disp <= line_cnt;
          locked      <= good;
          state       <= good ? LOCKED : ACQUIRE;
          line_seen   <= 1'b0;
          frame_bad   <= 1'b0;
          if ((state == LOCKED) && !good) begin
            err_pulse <= 1'b1;
            if (err_cnt != 8'd255)
              err_cnt <= err_cnt + 8'd1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_rgb_de_receiver.sv
// Directed bench for rgb_de_receiver with a short vertical-blank threshold and small frames.
module tb_rgb_de_receiver;

  localparam int V   = 64;
  localparam int W   = 20;
  localparam int H   = 5;
  localparam int HBL = 45;
  localparam int VBL = 200;
`ifdef RGB_RX_ID_CHECK_EN
  localparam logic LOCK_OK = 1'b0;  // no panel ID maps to the small bench frames
`else
  localparam logic LOCK_OK = 1'b1;
`endif

  logic        lcd_clk, sys_rst, in_de;
  logic [15:0] lcd_id, in_rgb;
  logic        pix_valid, frame_start, line_end, frame_end, locked, err_pulse;
  logic [15:0] pix_data;
  logic [10:0] pix_xpos, pix_ypos, meas_h_disp, meas_v_disp;
  logic [7:0]  err_cnt;

  rgb_de_receiver #(.VBLANK_MIN(V), .GAP_W(12)) dut (
    .lcd_clk(lcd_clk), .sys_rst(sys_rst), .lcd_id(lcd_id),
    .in_de(in_de), .in_rgb(in_rgb),
    .pix_valid(pix_valid), .pix_data(pix_data),
    .pix_xpos(pix_xpos), .pix_ypos(pix_ypos),
    .frame_start(frame_start), .line_end(line_end), .frame_end(frame_end),
    .meas_h_disp(meas_h_disp), .meas_v_disp(meas_v_disp),
    .locked(locked), .err_pulse(err_pulse), .err_cnt(err_cnt)
  );

  initial lcd_clk = 1'b0;
  always #5 lcd_clk = ~lcd_clk;

  int cyc = 0;
  always @(posedge lcd_clk) cyc = cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic outs_nz();
    return |{pix_valid, pix_data, pix_xpos, pix_ypos, frame_start, line_end, frame_end,
             meas_h_disp, meas_v_disp, locked, err_pulse, err_cnt};
  endfunction

  // Event recorder, sampled on the falling edge.
  int          pv_cnt, fe_cnt, fs_cnt, ep_cnt, le_cnt, fe_cyc, first_pv_cyc;
  logic [10:0] le_x, le_y;
  logic [15:0] le_data, fs_data;
  logic        lock_at_fe, ep_at_fe;

  always @(negedge lcd_clk) begin
    if (pix_valid) begin
      if (pv_cnt == 0) first_pv_cyc = cyc;
      pv_cnt++;
    end
    if (line_end) begin
      le_x = pix_xpos; le_y = pix_ypos; le_data = pix_data; le_cnt++;
    end
    if (frame_start) begin
      fs_cnt++; fs_data = pix_data;
    end
    if (frame_end) begin
      fe_cnt++; fe_cyc = cyc; lock_at_fe = locked; ep_at_fe = err_pulse;
    end
    if (err_pulse) ep_cnt++;
  end

  task automatic clear_mon();
    pv_cnt = 0; fe_cnt = 0; fs_cnt = 0; ep_cnt = 0; le_cnt = 0;
    fe_cyc = 0; first_pv_cyc = 0;
    le_x = '0; le_y = '0; le_data = '0; fs_data = '0;
    lock_at_fe = 1'b0; ep_at_fe = 1'b0;
  endtask

  int de_first_cyc, de_last_cyc;

  task automatic tick();
    @(posedge lcd_clk);
    #1;
  endtask

  task automatic idle(input int n);
    in_de = 1'b0;
    in_rgb = 16'd0;
    repeat (n) tick();
  endtask

  task automatic send_beat(input int x, input int y);
    in_de = 1'b1;
    in_rgb = {4'hA, y[3:0], x[7:0]};
    de_last_cyc = cyc;
    tick();
  endtask

  task automatic send_line(input int len, input int y);
    for (int x = 0; x < len; x++) send_beat(x, y);
  endtask

  task automatic send_frame(input int bad_line, input int bad_len);
    de_first_cyc = cyc;
    for (int y = 0; y < H; y++) begin
      send_line((y == bad_line) ? bad_len : W, y);
      idle((y == H - 1) ? VBL : HBL);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    sys_rst = 1'b1; lcd_id = 16'h7084; in_de = 1'b0; in_rgb = 16'h1234;
    clear_mon();
    repeat (3) tick();
    check_val("rst_outs", {31'd0, outs_nz()}, 32'd0);

    // Idle past the blank threshold: leaves SEARCH silently.
    sys_rst = 1'b0;
    idle(V + 10);
    check_val("idle_fe", fe_cnt, 0);
    check_val("idle_outs", {31'd0, outs_nz()}, 32'd0);

    // Frame 1
    clear_mon();
    send_frame(-1, 0);
    check_val("f1_pv_cnt", pv_cnt, W * H);
    check_val("f1_latency", first_pv_cyc - de_first_cyc, 2);
    check_val("f1_fs_cnt", fs_cnt, 1);
    check_val("f1_fs_data", fs_data, 16'hA000);
    check_val("f1_le_cnt", le_cnt, H);
    check_val("f1_last_x", le_x, W - 1);
    check_val("f1_last_y", le_y, H - 1);
    check_val("f1_last_data", le_data, 16'hA413);
    check_val("f1_fe_cnt", fe_cnt, 1);
    check_val("f1_fe_timing", fe_cyc - de_last_cyc, V + 3);
    check_val("f1_meas_h", meas_h_disp, W);
    check_val("f1_meas_v", meas_v_disp, H);
    check_val("f1_locked", locked, LOCK_OK);

    // Frame 2
    send_frame(-1, 0);
    check_val("f2_fe_cnt", fe_cnt, 2);
    check_val("f2_pv_cnt", pv_cnt, 2 * W * H);
    check_val("f2_locked", locked, LOCK_OK);
    check_val("f2_err_cnt", err_cnt, 0);

    // Frame 3 with one short line
    clear_mon();
    send_frame(2, W - 1);
    check_val("f3_pv_cnt", pv_cnt, W * H - 1);
    check_val("f3_fe_cnt", fe_cnt, 1);
    check_val("f3_lock_at_fe", lock_at_fe, 1'b0);
    check_val("f3_ep_at_fe", ep_at_fe, LOCK_OK);
    check_val("f3_ep_cnt", ep_cnt, LOCK_OK ? 1 : 0);
    check_val("f3_err_cnt", err_cnt, LOCK_OK ? 1 : 0);
    check_val("f3_meas_h", meas_h_disp, W);

    // Frame 4 relocks
    send_frame(-1, 0);
    check_val("f4_locked", locked, LOCK_OK);
    check_val("f4_err_cnt", err_cnt, LOCK_OK ? 1 : 0);

    // Reset mid-line
    for (int x = 0; x < 10; x++) send_beat(x, 0);
    sys_rst = 1'b1;
    send_beat(10, 0);
    check_val("midrst_outs", {31'd0, outs_nz()}, 32'd0);
    sys_rst = 1'b0;
    clear_mon();
    for (int x = 11; x < W; x++) send_beat(x, 0);
    idle(30);
    send_line(W, 1);
    idle(30);
    check_val("search_pv", pv_cnt, 0);
    idle(V);
    clear_mon();
    send_frame(-1, 0);
    check_val("rsf_pv_cnt", pv_cnt, W * H);
    check_val("rsf_fs_cnt", fs_cnt, 1);
    check_val("rsf_locked", locked, LOCK_OK);

    // Gap of V-1 keeps the frame; gap of V breaks it
    clear_mon();
    send_line(W, 0);
    idle(V - 1);
    send_line(W, 1);
    idle(3);
    check_val("gap63_y", le_y, 1);
    check_val("gap63_fe", fe_cnt, 0);
    idle(V + 2);
    check_val("gap64_fe", fe_cnt, 1);
    check_val("gap64_meas_v", meas_v_disp, 2);
    check_val("gap64_locked", locked, 1'b0);
    check_val("gap64_err_cnt", err_cnt, LOCK_OK ? 1 : 0);
    send_line(W, 0);
    idle(3);
    check_val("gap64_fs_cnt", fs_cnt, 2);
    check_val("gap64_y", le_y, 0);
    idle(VBL);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rgb_de_receiver.md
Name: rgb_de_receiver

Overview:
- DE-mode RGB565 video receiver: the receive end of our panel-drive interface, where only DE and RGB carry timing and HS/VS are tied high.
- Recovers frame and line boundaries from DE alone, and regenerates pixel coordinates.
- Measures the active resolution and tracks lock.
- Sits at the input of the loopback/capture path and feeds the frame-buffer writer and the recognition pipeline.

Parameters:
- VBLANK_MIN, 2048: DE-low run length (clocks) that marks a vertical blank. Must exceed the largest horizontal blank (320) and be below the smallest vertical blank.
- GAP_W, 12: width of the gap counter. Must satisfy 2^GAP_W > VBLANK_MIN.

Ports:
- lcd_clk  in  1  pixel clock; the only clock.
- sys_rst  in  1  synchronous, active-high reset.
- lcd_id  in  16  panel ID. Used only with RGB_RX_ID_CHECK_EN; otherwise ignored.
- in_de  in  1  incoming data enable.
- in_rgb  in  16  incoming RGB565 pixel.
- pix_valid  out  1  output pixel valid.
- pix_data  out  16  output pixel.
- pix_xpos  out  11  column within line, from 0.
- pix_ypos  out  11  line within frame, from 0.
- frame_start  out  1  marks the first pixel of a frame.
- line_end  out  1  marks the last pixel of a line.
- frame_end  out  1  single-cycle pulse at detected vertical blank.
- meas_h_disp  out  11  measured active width.
- meas_v_disp  out  11  measured active height.
- locked  out  1  resolution lock.
- err_pulse  out  1  single-cycle pulse on lock loss.
- err_cnt  out  8  lock-loss count, saturating at 255.

Behaviour:
- Reset (sys_rst=1 at an lcd_clk edge): all outputs are 0; state=SEARCH; gap counter, x/y counters and stored width are 0. Mid-frame reset aborts immediately; the next edge restarts in SEARCH.
- Pipeline: two register stages. Stage 1 registers in_de/in_rgb. Stage 2 drives the outputs using the next-DE lookahead. Latency from input to pix_* is exactly 2 cycles.
- Gap counter: counts consecutive in_de=0 samples and saturates at VBLANK_MIN; in_de=1 clears it.
  - blank_hit: the run reaches VBLANK_MIN.
  - New frame: in_de rises after a blank_hit run.
- frame_end: high exactly one cycle, VBLANK_MIN+2 cycles after the edge sampling the last DE-high beat. It fires only if at least one line was seen since the previous frame_end. It does not fire in SEARCH.
- pix_valid: equals delayed DE, but only in ACQUIRE or LOCKED. It is 0 in SEARCH, as are all frame/line strobes.
- pix_xpos:
  - 0 on the first beat of each DE run, +1 per beat.
  - Saturates at 2047, which also sets a line-width error.
- pix_ypos: 0 for the first line after a new frame, +1 on each DE rising edge. Saturates at 2047.
- frame_start: equals pix_valid & (x==0) & (y==0) & new frame.
- line_end: equals pix_valid with next delayed DE=0, i.e. aligned with the last pixel of the run.
- Width check: the first line's length is stored. Any later line of different length flags frame_bad. A DE run of length 1 counts as a line.
- meas_h_disp / meas_v_disp update at frame_end to (first-line width, line count).
- State machine:
  - SEARCH -> ACQUIRE on the first blank_hit after reset.
  - ACQUIRE -> LOCKED at frame_end if frame_bad=0. Otherwise it stays in ACQUIRE.
  - LOCKED stays LOCKED at frame_end if frame_bad=0 and the dimensions equal the stored meas values from the previous frame.
  - Otherwise LOCKED -> ACQUIRE, locked drops the same cycle as frame_end, err_pulse=1 for one cycle, and err_cnt increments (saturating at 255).
- locked: 1 only in LOCKED. It is registered and changes only on frame_end (or reset).
- Simultaneous events: in_de rising on the same edge the gap counter would reach VBLANK_MIN counts as blank_hit not reached, so no frame boundary.
- pix_data: in_rgb delayed 2 cycles when pix_valid=1, else 0.

Optional Feature:
- Macro: RGB_RX_ID_CHECK_EN.
- Defined: lcd_id maps to an expected resolution:
  - 4342 -> 480x272
  - 7084 -> 800x480
  - 7016 -> 1024x600
  - 4384 -> 800x480
  - 1018 -> 1280x800
  - default -> 480x272
- Defined: ACQUIRE->LOCKED and LOCKED stay additionally require the measured dimensions to equal the expected ones. A mismatch in LOCKED behaves as a lock loss.
- Not defined: lcd_id is unused and lock depends only on self-consistency.

Test Plan:
- Reset, then idle in_de=0 for VBLANK_MIN=64 (bench override) -> state ACQUIRE, no frame_end, all outputs 0.
- Two 480x272 frames (45-clock hblank, 200-clock vblank) -> pix_valid 2 cycles after in_de; last beat has x=479/y=271 with line_end=1; frame_end after frame 1 gives meas 480x272; locked=1 after frame 1.
- Locked, then one line of 479 beats in frame 3 -> locked=0 and err_pulse=1 at frame 3's frame_end; err_cnt=1; relock after a good frame 4.
- Reset asserted mid-line at x=200 -> next cycle all outputs 0, state SEARCH; no pix_valid until a 64-clock gap is seen.
- DE-low gap of exactly 63 between lines -> no frame boundary, y continues; gap of 64 -> frame_end, next line y=0 with frame_start=1.
- RGB_RX_ID_CHECK_EN with lcd_id=16'h7084 and 480x272 frames -> locked stays 0; with 800x480 frames -> locked=1 after the first good frame.
